wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter REGF_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, load-result buffer entries (power of two, at least 2).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive ALU wins before forced drain.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port alu_valid, input, 1, ALU-pipe result present this cycle (no backpressure).
REQ-007 SHALL have port alu_rd, input, 5, ALU destination register.
REQ-008 SHALL have port alu_data, input, REGF_WIDTH, ALU result.
REQ-009 SHALL have port alu_stall, output, 1, registered request for the ALU pipe to hold for one cycle.
REQ-010 SHALL have port lsu_valid, input, 1, load/long-latency result offered.
REQ-011 SHALL have port lsu_ready, output, 1, load result accepted when lsu_valid and lsu_ready are both high at a clock edge.
REQ-012 SHALL have port lsu_rd, input, 5, load destination register.
REQ-013 SHALL have port lsu_data, input, REGF_WIDTH, load result.
REQ-014 SHALL have port write_en, output, 1, register-file write strobe (registered).
REQ-015 SHALL have port rsW, output, 5, register-file write address (registered).
REQ-016 SHALL have port write_data, output, REGF_WIDTH, register-file write data (registered).
REQ-017 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current buffer occupancy.

Function
REQ-018 SHALL evaluate one grant per cycle; the granted write appears on write_en/rsW/write_data after the next rising edge (1-cycle latency).
REQ-019 SHALL give priority order: (1) ALU, when alu_valid=1, alu_rd!=0 and alu_stall=0; (2) FIFO head; (3) LSU bypass.
REQ-020 SHALL grant the LSU bypass only when the FIFO is empty, no ALU grant is made and an LSU transfer occurs; the bypassed entry is not enqueued.
REQ-021 SHALL enqueue an accepted LSU result whose rd!=0 and that is not bypassed, in FIFO order.
REQ-022 SHALL accept and silently discard an LSU transfer with lsu_rd=0 (no enqueue, no write).
REQ-023 SHALL treat an ALU result with alu_rd=0 as no request, leaving the slot free for the FIFO or the bypass.
REQ-024 SHALL drive lsu_ready = (fifo_count < FIFO_DEPTH) and rst_n; when full, lsu_ready=0 even if a pop occurs in the same cycle.
REQ-025 SHALL pop the FIFO head only in the cycle it is granted; simultaneous push and pop keeps fifo_count unchanged.
REQ-026 SHALL drive write_en=0 in the cycle after no grant; rsW and write_data then hold their previous values.
REQ-027 SHALL keep starve_cnt: +1 on each ALU grant while the FIFO is non-empty; cleared on any FIFO pop or when the FIFO is empty.
REQ-028 SHALL, when an increment would reach STARVE_LIMIT, clear starve_cnt and set alu_stall=1 for exactly the next cycle.
REQ-029 SHALL, while alu_stall=1, ignore alu_valid/alu_rd/alu_data and grant the FIFO head (or the bypass if the FIFO is empty).
REQ-030 SHALL NOT merge or reorder writes to the same rd; writes occur in grant order.
REQ-031 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force write_en=0, rsW=0, write_data=0, alu_stall=0, fifo_count=0, lsu_ready=0, starve_cnt=0, and both pointers to 0.
REQ-033 SHALL discard any buffered entries on reset assertion mid-operation; no write issues in the first cycle after release unless granted in that cycle.

Verification
REQ-034 SHALL be checked: alu_valid=1, rd=5, data=12345, no LSU -> next cycle write_en=1, rsW=5, write_data=12345.
REQ-035 SHALL be checked: the same cycle carries ALU rd=10/54321 and an LSU transfer rd=7/0xDEADBEEF with the FIFO empty -> cycle+1 writes x10; cycle+2 writes x7; fifo_count goes 1 then 0.
REQ-036 SHALL be checked: ALU write to x0 in the same cycle as a buffered LSU entry rd=3 -> next cycle writes x3, and no x0 write ever occurs.
REQ-037 SHALL be checked: ALU valid every cycle while 2 LSU entries are pushed -> lsu_ready=0 at fifo_count=2; after 4 ALU wins alu_stall=1 for one cycle, the FIFO head is written, and alu_stall returns to 0.
REQ-038 SHALL be checked: rst_n pulsed low with fifo_count=2 -> immediately write_en=0, fifo_count=0, lsu_ready=0; after release, lsu_ready=1 and no stale writes.
REQ-039 SHALL be checked: LSU transfer with lsu_rd=0 and data=0xFFFFFFFF -> accepted, fifo_count stays 0, no write_en pulse.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win the single write port, load
// results queue in a small FIFO, and a starvation counter forces periodic drains.
module wb_arbiter #(
  parameter int REGF_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [REGF_WIDTH-1:0]         alu_data,
  output logic                          alu_stall,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd,
  input  logic [REGF_WIDTH-1:0]         lsu_data,
  output logic                          write_en,
  output logic [4:0]                    rsW,
  output logic [REGF_WIDTH-1:0]         write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [4:0]            r_mem_rd   [FIFO_DEPTH];
  logic [REGF_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [SW-1:0]         r_starve_cnt;
  logic                  r_alu_stall;
  logic                  r_write_en;
  logic [4:0]            r_rsw;
  logic [REGF_WIDTH-1:0] r_write_data;

  logic                  w_alu_grant;
  logic                  w_empty;
  logic                  w_lsu_ready;
  logic                  w_lsu_xfer;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_grant;
  logic [4:0]            w_wr_rd;
  logic [REGF_WIDTH-1:0] w_wr_data;
  logic [SW-1:0]         w_starve_nxt;
  logic                  w_stall_set;
  logic [CW-1:0]         w_count_nxt;

  // While stalled, the ALU inputs are ignored entirely; rd=0 is never a request.
  assign w_alu_grant = alu_valid && (alu_rd != 5'd0) && !r_alu_stall;
  assign w_empty     = (r_count == '0);
  assign w_lsu_ready = rst_n && (r_count < DEPTH_C);
  assign w_lsu_xfer  = lsu_valid && w_lsu_ready;
  assign w_pop       = !w_alu_grant && !w_empty;
  assign w_bypass    = !w_alu_grant && w_empty && w_lsu_xfer && (lsu_rd != 5'd0);
  assign w_push      = w_lsu_xfer && (lsu_rd != 5'd0) && !w_bypass;

  always_comb begin
    w_grant   = 1'b0;
    w_wr_rd   = r_rsw;
    w_wr_data = r_write_data;
    if (w_alu_grant) begin
      w_grant   = 1'b1;
      w_wr_rd   = alu_rd;
      w_wr_data = alu_data;
    end else if (w_pop) begin
      w_grant   = 1'b1;
      w_wr_rd   = r_mem_rd[r_rptr];
      w_wr_data = r_mem_data[r_rptr];
    end else if (w_bypass) begin
      w_grant   = 1'b1;
      w_wr_rd   = lsu_rd;
      w_wr_data = lsu_data;
    end
  end

  // Starvation only accrues while loads are actually waiting behind ALU wins.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    w_stall_set  = 1'b0;
    if (w_pop || w_empty) begin
      w_starve_nxt = '0;
    end else if (w_alu_grant) begin
      if (r_starve_cnt + SW'(1) == LIMIT_C) begin
        w_starve_nxt = '0;
        w_stall_set  = 1'b1;
      end else begin
        w_starve_nxt = r_starve_cnt + SW'(1);
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_alu_stall  <= 1'b0;
      r_write_en   <= 1'b0;
      r_rsw        <= '0;
      r_write_data <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count      <= w_count_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_alu_stall  <= w_stall_set;
      r_write_en   <= w_grant;
      if (w_grant) begin
        r_rsw        <= w_wr_rd;
        r_write_data <= w_wr_data;
      end
    end
  end

  // Buffer payload needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= lsu_rd;
      r_mem_data[r_wptr] <= lsu_data;
    end
  end

  assign alu_stall  = r_alu_stall;
  assign lsu_ready  = w_lsu_ready;
  assign write_en   = r_write_en;
  assign rsW        = r_rsw;
  assign write_data = r_write_data;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Table-driven bench for wb_arbiter with a write scoreboard and hand-written
// sequences for reset, write-hold and mid-operation reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        write_en;
  logic [4:0]  rsW;
  logic [31:0] write_data;
  logic [1:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [1:0]  cnt;
    logic        rdy;
    logic        stall;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t  sb[$];
  vec_t vt[$];

  wb_arbiter #(.REGF_WIDTH(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .write_en(write_en), .rsW(rsW), .write_data(write_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                              input logic [1:0] cnt, input logic rdy, input logic stall);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.we = we; v.wrd = wrd; v.wd = wd;
    v.cnt = cnt; v.rdy = rdy; v.stall = stall;
    return v;
  endfunction

  // Drive one cycle of stimulus at a falling edge, then check after the next falling edge.
  task automatic step(input vec_t v, input string tag);
    wr_t e;
    alu_valid = v.av; alu_rd = v.lrd; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    if (v.we) sb.push_back({v.wrd, v.wd});
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".we"}, 32'(write_en), 32'(v.we));
    if (write_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s.sb actual=write rd=%0d data=%0h required=no write", tag, rsW, write_data);
      end else begin
        e = sb.pop_front();
        chk({tag, ".rd"}, 32'(rsW), 32'(e.rd));
        chk({tag, ".data"}, write_data, e.d);
      end
    end else if (v.we && sb.size() != 0) begin
      e = sb.pop_front();
    end
    chk({tag, ".cnt"}, 32'(fifo_count), 32'(v.cnt));
    chk({tag, ".rdy"}, 32'(lsu_ready), 32'(v.rdy));
    chk({tag, ".stall"}, 32'(alu_stall), 32'(v.stall));
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Single ALU write, then ALU + LSU collision with an empty FIFO.
    vt.push_back(mk(1, 5, 12345, 0, 0, 0,                    1, 5, 12345, 0, 1, 0));
    vt.push_back(idle);
    vt.push_back(mk(1, 10, 54321, 1, 7, 32'hDEADBEEF,        1, 10, 54321, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,                        1, 7, 32'hDEADBEEF, 0, 1, 0));
    vt.push_back(idle);
    // LSU to x0 is swallowed.
    vt.push_back(mk(0, 0, 0, 1, 0, 32'hFFFFFFFF,             0, 0, 0, 0, 1, 0));
    // Buffered x3 drains when the ALU targets x0.
    vt.push_back(mk(1, 1, 111, 1, 3, 333,                    1, 1, 111, 1, 1, 0));
    vt.push_back(mk(1, 0, 999, 0, 0, 0,                      1, 3, 333, 0, 1, 0));
    vt.push_back(mk(1, 0, 999, 0, 0, 0,                      0, 0, 0, 0, 1, 0));
    // Bypass with empty FIFO, with and without an x0 ALU result.
    vt.push_back(mk(0, 0, 0, 1, 9, 32'h99,                   1, 9, 32'h99, 0, 1, 0));
    vt.push_back(mk(1, 0, 7, 1, 12, 32'hC0C0,                1, 12, 32'hC0C0, 0, 1, 0));
    // Starvation: fill FIFO under continuous ALU traffic, forced drain after 4 wins.
    vt.push_back(mk(1, 20, 32'h20, 1, 21, 32'h21,            1, 20, 32'h20, 1, 1, 0));
    vt.push_back(mk(1, 22, 32'h22, 1, 23, 32'h23,            1, 22, 32'h22, 2, 0, 0));
    vt.push_back(mk(1, 24, 32'h24, 1, 25, 32'h25,            1, 24, 32'h24, 2, 0, 0));
    vt.push_back(mk(1, 26, 32'h26, 0, 0, 0,                  1, 26, 32'h26, 2, 0, 0));
    vt.push_back(mk(1, 27, 32'h27, 0, 0, 0,                  1, 27, 32'h27, 2, 0, 1));
    vt.push_back(mk(1, 28, 32'h28, 1, 25, 32'h25,            1, 21, 32'h21, 1, 1, 0));
    vt.push_back(mk(1, 29, 32'h29, 0, 0, 0,                  1, 29, 32'h29, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,                        1, 23, 32'h23, 0, 1, 0));
    vt.push_back(idle);

    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    #1;
    chk("rst.we", 32'(write_en), 0);
    chk("rst.rd", 32'(rsW), 0);
    chk("rst.data", write_data, 0);
    chk("rst.cnt", 32'(fifo_count), 0);
    chk("rst.rdy", 32'(lsu_ready), 0);
    chk("rst.stall", 32'(alu_stall), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.rdy", 32'(lsu_ready), 1);

    for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("v%0d", i));

    chk("hold.rd", 32'(rsW), 23);
    chk("hold.data", write_data, 32'h23);

    // Fill the FIFO, then pulse reset and make sure nothing buffered survives.
    step(mk(1, 2, 2, 1, 4, 4, 1, 2, 2, 1, 1, 0), "mr0");
    step(mk(1, 2, 3, 1, 5, 5, 1, 2, 3, 2, 0, 0), "mr1");
    rst_n = 1'b0;
    alu_valid = 0; lsu_valid = 0;
    #1;
    chk("mr.we", 32'(write_en), 0);
    chk("mr.cnt", 32'(fifo_count), 0);
    chk("mr.rdy", 32'(lsu_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr.rel.rdy", 32'(lsu_ready), 1);
    for (int i = 0; i < 3; i++) step(idle, $sformatf("post%0d", i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
